ram_burst_initiator: RTL
========================

// Module: ram_burst_initiator
// PURPOSE
//  Initiator side of the strobe/flag RAM access interface. Accepts burst commands
//  (read or write, start address, length) and sequences single-byte ram_rd_ins /
//  ram_wr_ins strobes with addresses, completing each access by the RAM's idle flags.
//  Write bytes arrive on a valid/ready stream; read bytes leave on a valid/ready stream.
// PARAMETERS
//  DATA_WIDTH   8     byte width of RAM data buses and streams
//  ADDR_DEPTH   512   RAM depth in words; the address wraps modulo this value
//  ADDR_WIDTH   $clog2(ADDR_DEPTH)  RAM address width
//  LEN_WIDTH    10    width of cmd_len (maximum burst is 2**LEN_WIDTH-1 bytes)
//  ACK_TIMEOUT  15    maximum cycles spent in either ACK phase before abort
// PORTS
//  clk          in   1           system clock, rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  cmd_valid    in   1           command offered
//  cmd_ready    out  1           command accepted when cmd_valid && cmd_ready
//  cmd_rd       in   1           1 = read burst, 0 = write burst
//  cmd_addr     in   ADDR_WIDTH  start address
//  cmd_len      in   LEN_WIDTH   byte count; 0 = empty burst
//  wr_data      in   DATA_WIDTH  write stream byte
//  wr_valid     in   1           write byte valid
//  wr_ready     out  1           write byte taken when wr_valid && wr_ready
//  rd_data      out  DATA_WIDTH  read stream byte, registered
//  rd_valid     out  1           read byte valid; holds until rd_ready
//  rd_ready     in   1           downstream accepts rd_data
//  done         out  1           one-cycle pulse at burst end, normal or aborted
//  err          out  1           sticky timeout flag; cleared on next command accept
//  ram_addr_wr  out  ADDR_WIDTH  write address, stable from strobe until ACK done
//  ram_data_wr  out  DATA_WIDTH  write data, stable from strobe until ACK done
//  ram_wr_ins   out  1           write strobe, high exactly one cycle per byte
//  ram_flag_wr  in   1           RAM write side idle
//  ram_addr_rd  out  ADDR_WIDTH  read address, stable from strobe until ACK done
//  ram_rd_ins   out  1           read strobe, high exactly one cycle per byte
//  ram_flag_rd  in   1           RAM read side idle
//  ram_data_rd  in   DATA_WIDTH  RAM read data, valid once flag_rd returns high
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1; wr_ready=0; rd_valid=0; rd_data=0; done=0; err=0;
//   strobes=0; RAM addresses and data = 0; address and remaining counters = 0.
//  All outputs are registered. The strobe is a single-cycle pulse, because the RAM
//   edge-detects it and needs a low phase between accesses.
//  FSM:
//   IDLE: cmd_ready=1. On accept, latch addr and len and clear err.
//    len==0 -> done pulse next cycle; stay IDLE.
//    cmd_rd=1 -> RD_STB; otherwise -> WR_DATA.
//   WR_DATA: wr_ready=1. On a wr_valid handshake, latch ram_data_wr and
//    ram_addr_wr=addr, then -> WR_STB. wr_ready is 0 in every other state.
//   WR_STB: ram_wr_ins=1 for one cycle -> WR_ACK_LO.
//   WR_ACK_LO: wait for ram_flag_wr==0 (busy seen) -> WR_ACK_HI.
//   WR_ACK_HI: wait for ram_flag_wr==1. Then addr <= addr+1 mod ADDR_DEPTH and
//    remaining--. If remaining is now 0 -> DONE; otherwise -> WR_DATA.
//   RD_STB: ram_addr_rd=addr; ram_rd_ins=1 for one cycle -> RD_ACK_LO.
//   RD_ACK_LO / RD_ACK_HI: same as the write ACK phases, using ram_flag_rd.
//    On flag high, capture rd_data <= ram_data_rd, set rd_valid=1 -> RD_OUT.
//   RD_OUT: hold rd_data/rd_valid until rd_ready. Then clear rd_valid, increment
//    addr, decrement remaining, and go to RD_STB, or to DONE if remaining==0.
//    rd_valid=1 && rd_ready=1 in the same cycle completes the transfer.
//   DONE: done=1 for one cycle -> IDLE.
//  Timeout: a per-ACK-phase counter resets on entry to each ACK state. If it reaches
//   ACK_TIMEOUT, set err=1 and go to DONE. The remaining bytes are dropped, no
//   rd_valid is raised for the failed byte, and the RAM must still see no extra strobe.
//  Address wrap: ADDR_DEPTH-1 + 1 -> 0; a burst may cross the top of memory.
//  A new command is not accepted until DONE completes; cmd_ready=0 outside IDLE.
//  Reset asserted mid-burst: immediate return to reset values; partial burst is lost.
// TESTING
//  Bench uses a behavioural RAM model: flag drops 2 cycles after a strobe edge and
//   returns 1 cycle later; flag_rd starts low after reset until the first read.
//  Write addr=5 len=3 bytes A1,B2,C3 -> mem[5..7]=A1,B2,C3; 3 wr_ins pulses each
//   1 cycle wide; done pulses once; err=0.
//  Read addr=5 len=3 with rd_ready stuck at 0 for 4 cycles -> rd_data=A1 held stable;
//   no second rd_ins until the handshake; then B2 and C3 arrive in order.
//  Write addr=510 len=4 with DEPTH=512 -> writes to addresses 510,511,0,1.
//  cmd_len=0 -> no strobe; done pulses 1 cycle after accept; cmd_ready stays 1.
//  RAM model never drops flag_wr -> err=1 and done after ACK_TIMEOUT cycles, FSM in
//   IDLE. Next accepted command clears err. rst_n pulsed mid-read -> rd_valid=0 at once.

Source files
------------

// File: rtl/ram_burst_initiator.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_initiator
// Description : Initiator side of a strobe/flag RAM access interface. Accepts
//               burst commands (read or write, start address, byte length)
//               and issues one single-cycle ram_wr_ins / ram_rd_ins strobe per
//               byte. Each access completes when the RAM idle flag is seen
//               dropping and then returning high. Write bytes arrive on a
//               valid/ready stream; read bytes leave on a valid/ready stream.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_rd, cmd_addr, cmd_len  burst direction, start address, byte count
//   wr_data/wr_valid/wr_ready  write byte stream (in)
//   rd_data/rd_valid/rd_ready  read byte stream (out, registered)
//   done                       one-cycle pulse at end of every burst
//   err                        sticky ACK timeout flag, cleared on accept
//   ram_addr_wr, ram_data_wr   write address/data, held through the ACK
//   ram_wr_ins, ram_flag_wr    write strobe / RAM write-side idle flag
//   ram_addr_rd                read address, held through the ACK
//   ram_rd_ins, ram_flag_rd    read strobe / RAM read-side idle flag
//   ram_data_rd                RAM read data, valid once flag_rd is high
// ============================================================================
module ram_burst_initiator #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_DEPTH  = 512,
  parameter int ADDR_WIDTH  = $clog2(ADDR_DEPTH),
  parameter int LEN_WIDTH   = 10,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] ram_addr_wr,
  output logic [DATA_WIDTH-1:0] ram_data_wr,
  output logic                  ram_wr_ins,
  input  logic                  ram_flag_wr,
  output logic [ADDR_WIDTH-1:0] ram_addr_rd,
  output logic                  ram_rd_ins,
  input  logic                  ram_flag_rd,
  input  logic [DATA_WIDTH-1:0] ram_data_rd
);

  localparam int TO_WIDTH = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_WIDTH-1:0]   C_ACK_LAST = TO_WIDTH'(ACK_TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_TOP = ADDR_WIDTH'(ADDR_DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_DATA   = 4'd1,
    S_WR_STB    = 4'd2,
    S_WR_ACK_LO = 4'd3,
    S_WR_ACK_HI = 4'd4,
    S_RD_STB    = 4'd5,
    S_RD_ACK_LO = 4'd6,
    S_RD_ACK_HI = 4'd7,
    S_RD_OUT    = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [TO_WIDTH-1:0]   r_ack_cnt;

  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [LEN_WIDTH-1:0]  w_remaining_dec;
  logic                  w_last_byte;
  logic                  w_ack_expired;

  // Address wraps explicitly so non-power-of-two depths also work.
  assign w_addr_next     = (r_addr == C_ADDR_TOP) ? '0 : r_addr + ADDR_WIDTH'(1);
  assign w_remaining_dec = r_remaining - LEN_WIDTH'(1);
  assign w_last_byte     = (r_remaining == LEN_WIDTH'(1));
  assign w_ack_expired   = (r_ack_cnt == C_ACK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_ack_cnt   <= '0;
      cmd_ready   <= 1'b1;
      wr_ready    <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ram_addr_wr <= '0;
      ram_data_wr <= '0;
      ram_wr_ins  <= 1'b0;
      ram_addr_rd <= '0;
      ram_rd_ins  <= 1'b0;
    end else begin
      // Pulse outputs default low; states that need them raise them for
      // exactly the one cycle after the transition.
      done       <= 1'b0;
      ram_wr_ins <= 1'b0;
      ram_rd_ins <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            err         <= 1'b0;
            r_addr      <= cmd_addr;
            r_remaining <= cmd_len;
            if (cmd_len == '0) begin
              done <= 1'b1;                  // empty burst: stay in IDLE
            end else if (cmd_rd) begin
              cmd_ready   <= 1'b0;
              ram_addr_rd <= cmd_addr;
              ram_rd_ins  <= 1'b1;
              r_state     <= S_RD_STB;
            end else begin
              cmd_ready <= 1'b0;
              wr_ready  <= 1'b1;
              r_state   <= S_WR_DATA;
            end
          end
        end

        S_WR_DATA: begin
          if (wr_valid) begin                // wr_ready is high throughout
            wr_ready    <= 1'b0;
            ram_data_wr <= wr_data;
            ram_addr_wr <= r_addr;
            ram_wr_ins  <= 1'b1;
            r_state     <= S_WR_STB;
          end
        end

        S_WR_STB: begin
          r_ack_cnt <= '0;
          r_state   <= S_WR_ACK_LO;
        end

        S_WR_ACK_LO: begin
          if (!ram_flag_wr) begin
            r_ack_cnt <= '0;
            r_state   <= S_WR_ACK_HI;
          end else if (w_ack_expired) begin
            err     <= 1'b1;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ack_cnt <= r_ack_cnt + TO_WIDTH'(1);
          end
        end

        S_WR_ACK_HI: begin
          if (ram_flag_wr) begin
            r_addr      <= w_addr_next;
            r_remaining <= w_remaining_dec;
            if (w_last_byte) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              wr_ready <= 1'b1;
              r_state  <= S_WR_DATA;
            end
          end else if (w_ack_expired) begin
            err     <= 1'b1;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ack_cnt <= r_ack_cnt + TO_WIDTH'(1);
          end
        end

        S_RD_STB: begin
          r_ack_cnt <= '0;
          r_state   <= S_RD_ACK_LO;
        end

        S_RD_ACK_LO: begin
          if (!ram_flag_rd) begin
            r_ack_cnt <= '0;
            r_state   <= S_RD_ACK_HI;
          end else if (w_ack_expired) begin
            err     <= 1'b1;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ack_cnt <= r_ack_cnt + TO_WIDTH'(1);
          end
        end

        S_RD_ACK_HI: begin
          if (ram_flag_rd) begin
            rd_data  <= ram_data_rd;
            rd_valid <= 1'b1;
            r_state  <= S_RD_OUT;
          end else if (w_ack_expired) begin
            // Failed byte is dropped: no rd_valid for it.
            err     <= 1'b1;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ack_cnt <= r_ack_cnt + TO_WIDTH'(1);
          end
        end

        S_RD_OUT: begin
          if (rd_ready) begin
            rd_valid    <= 1'b0;
            r_addr      <= w_addr_next;
            r_remaining <= w_remaining_dec;
            if (w_last_byte) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              ram_addr_rd <= w_addr_next;
              ram_rd_ins  <= 1'b1;
              r_state     <= S_RD_STB;
            end
          end
        end

        S_DONE: begin
          cmd_ready <= 1'b1;
          r_state   <= S_IDLE;
        end

        default: begin
          wr_ready  <= 1'b0;
          rd_valid  <= 1'b0;
          cmd_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
